cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Single-broadcast Common Data Bus arbiter for the Tomasulo core.
- Arbitrates result producers (ALU RS, LS buffer, branch unit) onto one CDB per cycle, using round-robin priority and a registered broadcast.
- Drives the CDB consumed by the reservation stations, LS buffer and ROB.
- Replaces per-unit direct CDB drives; units hold results until granted.

Parameters:
- NUM_REQ, 3, number of producers (index 0 = ALU, 1 = LS buffer, 2 = branch).
- TAG_W, 4, ROB tag width; tag 0 is the reserved free tag.
- DATA_W, 32, result data width.
- RS_W, 3, reservation-station index width returned with the grant.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  misprediction flush from ROB (mispredictionRst).
- req_valid  in  NUM_REQ  per-producer result valid.
- req_tag  in  NUM_REQ*TAG_W  flattened destination tags; producer i occupies [i*TAG_W +: TAG_W].
- req_data  in  NUM_REQ*DATA_W  flattened result data.
- req_rsnum  in  NUM_REQ*RS_W  flattened originating RS index.
- req_grant  out  NUM_REQ  one-hot combinational grant in the current cycle.
- cdb_valid  out  1  registered broadcast valid.
- cdb_src  out  NUM_REQ  one-hot source of the broadcast.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_data  out  DATA_W  broadcast data.
- cdb_rsnum  out  RS_W  RS index, so the source frees its entry.

Behaviour:
- Reset (rst=1 at posedge): cdb_valid=0, cdb_src=0, cdb_tag=0, cdb_data=0, cdb_rsnum=0, rr_ptr=0. req_grant is forced to 0 while rst is high.
- Handshake: a producer asserts req_valid with stable tag, data and rsnum until it sees req_grant[i]=1 in that cycle. The transfer completes on that posedge. The producer may deassert req_valid, or present a new result, in the next cycle.
- Grant is combinational: the first asserted req_valid searching from rr_ptr upward, wrapping modulo NUM_REQ. At most one bit is set. req_grant is 0 when no request is valid.
- Latency: a result granted in cycle N appears on cdb_* in cycle N+1, held for exactly one cycle. cdb_valid drops in cycle N+2 unless another grant occurs.
- Pointer update: on any grant to index g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Starvation bound: a continuously valid producer is granted within NUM_REQ cycles.
- Idle cycle: cdb_valid=0 and cdb_src=0. cdb_tag, cdb_data and cdb_rsnum are zeroed, so the tag equals the free tag.
- Flush: while flush=1, req_grant=0 and cdb_valid is registered 0. rr_ptr resets to 0. A broadcast already registered in the flush cycle still completes; consumers drop it under flush.
- Simultaneous flush and rst: rst dominates, with an identical outcome.
- A request with tag 0 is granted and broadcast unchanged. Tag checking is the consumer's job.
- Fully back-to-back broadcasts, one per cycle, are supported with no bubble.

Optional Feature:
- Macro CDB_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt, width NUM_REQ*16.
  - Each per-producer counter increments once for each cycle in which req_valid[i]=1 and req_grant[i]=0, and saturates at 16'hFFFF.
  - Counters clear on rst only, not on flush.
- Undefined: no port and no counters. Arbitration behaviour is identical in both builds.

Decomposition:
- Shared defines header:
  - tag width and tagFree;
  - data width;
  - aluRSWidth;
  - producer index constants SRC_ALU=0, SRC_LSB=1, SRC_BR=2.
- Sub-module rr_arbiter (NUM_REQ): combinational round-robin grant from req_valid and rr_ptr, plus the next-pointer calculation.
- The top level holds the output register, the pointer register, flush gating and the optional counters.

Test Plan:
- Reset, then a single request: ALU requests tag 5, data 0x1234, rsnum 2 in cycle 1. req_grant=001 in cycle 1. Cycle 2: cdb_valid=1, src=001, tag=5, data=0x1234, rsnum=2. Cycle 3: cdb_valid=0.
- All three producers valid continuously from rr_ptr=0: grants 001, 010, 100, 001 in consecutive cycles, and the CDB shows a matching src sequence with no bubbles.
- After a grant to LSB (rr_ptr=2), branch and ALU both request: branch is granted first, then ALU.
- Flush while ALU and LSB are requesting: req_grant=0 that cycle, and cdb_valid=0 in the next cycle. The cycle after flush deasserts, ALU is granted (rr_ptr=0).
- rst asserted mid-stream with cdb_valid=1: in the next cycle all cdb_* are 0 and req_grant stays 0 while rst is high.
- With CDB_STALL_CNT_EN: LSB waits 3 cycles behind ALU and branch, so stall_cnt for LSB reads 2 at the grant cycle. Holding a request ungranted for 70000 cycles under forced flush saturates the counter at 0xFFFF.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: tag/data/RS widths, the free tag and producer indices.
// Optional stall counters (macro CDB_STALL_CNT_EN) use STALL_W bits per producer.
package cdb_arbiter_pkg;

  localparam int CDB_TAG_W   = 4;
  localparam int CDB_DATA_W  = 32;
  localparam int ALU_RS_W    = 3;
  localparam int CDB_NUM_REQ = 3;
  localparam int STALL_W     = 16;

  localparam logic [CDB_TAG_W-1:0] TAG_FREE = '0;

  localparam int SRC_ALU = 0;
  localparam int SRC_LSB = 1;
  localparam int SRC_BR  = 2;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first valid request at or above rr_ptr, wrapping.
// Also yields the pointer that follows the winner.
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  localparam int PTR_W  = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   next_ptr
);

  int   idx;
  logic found;

  always_comb begin
    grant    = '0;
    next_ptr = rr_ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = PTR_W'((idx + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: combinational grant, broadcast registered one cycle later.
// Optional per-producer stall counters when CDB_STALL_CNT_EN is defined.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = CDB_NUM_REQ,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W,
  parameter int RS_W    = ALU_RS_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*RS_W-1:0]   req_rsnum,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic                      cdb_valid,
  output logic [NUM_REQ-1:0]        cdb_src,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [RS_W-1:0]           cdb_rsnum
`ifdef CDB_STALL_CNT_EN
  ,
  output logic [NUM_REQ*STALL_W-1:0] stall_cnt
`endif
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [NUM_REQ-1:0] arb_grant;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   next_ptr;
  logic [TAG_W-1:0]   sel_tag;
  logic [DATA_W-1:0]  sel_data;
  logic [RS_W-1:0]    sel_rsnum;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .next_ptr  (next_ptr)
  );

  assign req_grant = (rst || flush) ? '0 : arb_grant;

  // One-hot AND-OR select; no grant yields all zeros, i.e. the free tag.
  always_comb begin
    sel_tag   = TAG_FREE;
    sel_data  = '0;
    sel_rsnum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_grant[i]) begin
        sel_tag   = sel_tag   | req_tag[i*TAG_W +: TAG_W];
        sel_data  = sel_data  | req_data[i*DATA_W +: DATA_W];
        sel_rsnum = sel_rsnum | req_rsnum[i*RS_W +: RS_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_src   <= '0;
      cdb_tag   <= TAG_FREE;
      cdb_data  <= '0;
      cdb_rsnum <= '0;
      rr_ptr    <= '0;
    end else begin
      cdb_valid <= |req_grant;
      cdb_src   <= req_grant;
      cdb_tag   <= sel_tag;
      cdb_data  <= sel_data;
      cdb_rsnum <= sel_rsnum;
      if (flush) begin
        rr_ptr <= '0;
      end else if (|req_grant) begin
        rr_ptr <= next_ptr;
      end
    end
  end

`ifdef CDB_STALL_CNT_EN
  // Counts cycles a producer waited; flush gating counts as waiting.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        stall_cnt[i*STALL_W +: STALL_W] <= '0;
      end else if (req_valid[i] && !req_grant[i] &&
                   (stall_cnt[i*STALL_W +: STALL_W] != {STALL_W{1'b1}})) begin
        stall_cnt[i*STALL_W +: STALL_W] <= stall_cnt[i*STALL_W +: STALL_W] + STALL_W'(1);
      end
    end
  end
`endif

endmodule
